// File: rtl/iru_pkg.sv
// Shared IRU trig types: angle count, sin offset, sample format, scheduler states and one-hot LUT select.
package iru_pkg;

  localparam int IRU_NUM_ANGLES = 36;
  localparam int IRU_SIN_OFFSET = 27;

  typedef logic [8:0] iru_trig_t;

  typedef enum logic [1:0] {
    IDLE,
    COS,
    SIN,
    RESP
  } iru_trig_state_e;

  // Index k selects bit (35-k); out-of-range indices select nothing.
  function automatic logic [35:0] iru_onehot36(input logic [5:0] k);
    logic [35:0] v;
    v = '0;
    if (k < 6'(IRU_NUM_ANGLES)) begin
      v = 36'h8_0000_0000 >> k;
    end
    return v;
  endfunction

endpackage

// File: rtl/iru_cos_lut.sv
// Combinational cos(k*10deg) table, sign-magnitude with 128 = 1.0, selected by a one-hot d (bit 35-k).
// d = 0 yields q = 0; index 27 stores a negative zero that consumers are expected to normalise.
module iru_cos_lut
  import iru_pkg::*;
(
  input  logic [35:0] d,
  output iru_trig_t   q
);

  // First-quadrant magnitudes, truncated (not rounded).
  function automatic logic [7:0] quad_mag(input int a);
    logic [7:0] m;
    case (a)
      0:       m = 8'd128;
      1:       m = 8'd126;
      2:       m = 8'd120;
      3:       m = 8'd110;
      4:       m = 8'd98;
      5:       m = 8'd82;
      6:       m = 8'd64;
      7:       m = 8'd43;
      8:       m = 8'd22;
      default: m = 8'd0;
    endcase
    return m;
  endfunction

  function automatic iru_trig_t lut_entry(input int i);
    iru_trig_t e;
    if (i <= 9)       e = {1'b0, quad_mag(i)};
    else if (i <= 18) e = {1'b1, quad_mag(18 - i)};
    else if (i <= 27) e = {1'b1, quad_mag(i - 18)};
    else              e = {1'b0, quad_mag(36 - i)};
    return e;
  endfunction

  always_comb begin
    q = '0;
    for (int i = 0; i < IRU_NUM_ANGLES; i++) begin
      if (d[35 - i]) begin
        q = q | lut_entry(i);
      end
    end
  end

endmodule

// File: rtl/iru_trig_sched.sv
// Round-robin share of one cos LUT between NUM_REQ requesters; grant in cycle N -> rsp_valid in N+3.
// The response is held until rsp_ready and no new grant is issued until it drains (1 request per 4 cycles max).
module iru_trig_sched
  import iru_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*6-1:0] req_angle,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output iru_trig_t            rsp_cos,
  output iru_trig_t            rsp_sin,
  output logic                 rsp_err
);

  iru_trig_state_e r_state;
  iru_trig_state_e w_state_nxt;

  logic [ID_W-1:0] r_rr;
  logic [ID_W-1:0] r_gnt;
  logic [5:0]      r_angle;
  logic            r_err;
  iru_trig_t       r_cos;
  iru_trig_t       r_sin;

  logic            w_gnt_vld;
  logic [ID_W-1:0] w_gnt_idx;
  logic [5:0]      w_gnt_angle;
  logic [ID_W-1:0] w_rr_nxt;
  logic [6:0]      w_sin_sum;
  logic [5:0]      w_sin_k;
  logic [35:0]     w_lut_d;
  iru_trig_t       w_lut_q;
  iru_trig_t       w_lut_norm;

  // Scan from the highest offset down so the nearest valid requester at/after r_rr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(r_rr) + i) % NUM_REQ]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = ID_W'((int'(r_rr) + i) % NUM_REQ);
      end
    end
    w_gnt_angle = req_angle[6*int'(w_gnt_idx) +: 6];
  end

  assign w_rr_nxt   = (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
  assign w_sin_sum  = {1'b0, r_angle} + 7'(IRU_SIN_OFFSET);
  assign w_sin_k    = r_err ? 6'h3F
                    : (w_sin_sum >= 7'(IRU_NUM_ANGLES)) ? 6'(w_sin_sum - 7'(IRU_NUM_ANGLES))
                    : w_sin_sum[5:0];
  assign w_lut_norm = (w_lut_q == 9'h100) ? '0 : w_lut_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = 1'b0;
    w_lut_d     = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          req_ready[w_gnt_idx] = 1'b1;
          w_state_nxt          = COS;
        end
      end
      COS: begin
        w_lut_d     = iru_onehot36(r_angle);
        w_state_nxt = SIN;
      end
      SIN: begin
        w_lut_d     = iru_onehot36(w_sin_k);
        w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= '0;
      r_gnt   <= '0;
      r_angle <= '0;
      r_err   <= 1'b0;
      r_cos   <= '0;
      r_sin   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_gnt   <= w_gnt_idx;
            r_angle <= w_gnt_angle;
            r_err   <= (w_gnt_angle >= 6'(IRU_NUM_ANGLES));
          end
        end
        COS: begin
          r_cos <= w_lut_norm;
          r_rr  <= w_rr_nxt;
        end
        SIN: begin
          r_sin <= w_lut_norm;
        end
        default: ;
      endcase
    end
  end

  iru_cos_lut u_cos_lut (
    .d (w_lut_d),
    .q (w_lut_q)
  );

  assign rsp_id  = r_gnt;
  assign rsp_cos = r_cos;
  assign rsp_sin = r_sin;
  assign rsp_err = r_err;

endmodule

// File: tb/tb_iru_trig_sched.sv
// Bench for iru_trig_sched: vector table and angle sweep through a response scoreboard, plus
// round-robin, response-stall and mid-flight reset sequences.
module tb_iru_trig_sched;
  import iru_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_angle = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_cos;
  logic [8:0]  rsp_sin;
  logic        rsp_err;

  typedef struct {
    int         id;
    int         angle;
    logic [8:0] cos;
    logic [8:0] sin;
    logic       err;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [8:0] cos;
    logic [8:0] sin;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   gnt_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  iru_trig_sched #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cos   (rsp_cos),
    .rsp_sin   (rsp_sin),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] enc(input real v);
    real a;
    int  m;
    a = (v < 0.0) ? -v : v;
    m = int'($floor(a * 128.0 + 1e-6));
    if (m == 0) return 9'h000;
    return {(v < 0.0), 8'(m)};
  endfunction

  function automatic exp_t model(input int id, input int ang);
    exp_t e;
    real  r;
    e.id  = 2'(id);
    e.err = (ang > 35);
    e.cos = '0;
    e.sin = '0;
    if (ang <= 35) begin
      r     = ang * 10.0 * 3.141592653589793 / 180.0;
      e.cos = enc($cos(r));
      e.sin = enc($sin(r));
    end
    return e;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Grant and response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req_ready != 4'b0) begin
        chk("gnt_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("gnt_has_valid", 32'(|(req_ready & req_valid)), 32'd1);
        gnt_log.push_back(idx_of(req_ready));
        gnt_cyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got response id %0d, expected none pending", rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_id",  32'(rsp_id),  32'(e.id));
          chk("rsp_cos", 32'(rsp_cos), 32'(e.cos));
          chk("rsp_sin", 32'(rsp_sin), 32'(e.sin));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic wait_grant(input string name, output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no grant within 20 cycles, expected one", name);
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_req(input int id, input int ang, input exp_t e);
    bit got;
    int lat;
    @(posedge clk);
    #1;
    req_valid             = 4'(1 << id);
    req_angle[6*id +: 6]  = 6'(ang);
    sb.push_back(e);
    wait_grant("gnt_timeout", got);
    if (!got) begin
      req_valid = '0;
      void'(sb.pop_back());
      return;
    end
    chk("gnt_req", 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 99;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    exp_t e;
    bit   got;

    tbl[0] = '{id: 0, angle: 0,  cos: 9'h080, sin: 9'h000, err: 1'b0};
    tbl[1] = '{id: 1, angle: 3,  cos: 9'h06E, sin: 9'h040, err: 1'b0};
    tbl[2] = '{id: 2, angle: 9,  cos: 9'h000, sin: 9'h080, err: 1'b0};
    tbl[3] = '{id: 3, angle: 18, cos: 9'h180, sin: 9'h000, err: 1'b0};
    tbl[4] = '{id: 0, angle: 40, cos: 9'h000, sin: 9'h000, err: 1'b1};
    tbl[5] = '{id: 1, angle: 35, cos: 9'h07E, sin: 9'h116, err: 1'b0};
    tbl[6] = '{id: 2, angle: 63, cos: 9'h000, sin: 9'h000, err: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_cos",   32'(rsp_cos),   32'd0);
    chk("rst_rsp_sin",   32'(rsp_sin),   32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      e.id  = 2'(tbl[i].id);
      e.cos = tbl[i].cos;
      e.sin = tbl[i].sin;
      e.err = tbl[i].err;
      do_req(tbl[i].id, tbl[i].angle, e);
    end

    // Full angle sweep; ends on requester 3 so the rr pointer is back at 0
    for (int k = 0; k <= 36; k++) begin
      int a;
      int id;
      a  = (k == 36) ? 63 : k;
      id = (k == 36) ? 3 : k % 4;
      do_req(id, a, model(id, a));
    end
    drain("sweep_drain");

    // All requesters valid: service order 0,1,2,3 spaced 4 cycles apart
    @(posedge clk);
    #1;
    gnt_log.delete();
    gnt_cyc.delete();
    req_angle = {6'd30, 6'd20, 6'd10, 6'd5};
    req_valid = 4'hF;
    sb.push_back(model(0, 5));
    sb.push_back(model(1, 10));
    sb.push_back(model(2, 20));
    sb.push_back(model(3, 30));
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (gnt_log.size() >= 4) break;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("rr_gnt_count", 32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() >= 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("rr_order",   32'(gnt_log[j]), 32'(j));
        chk("rr_spacing", 32'(gnt_cyc[j] - gnt_cyc[0]), 32'(4 * j));
      end
    end
    drain("rr_drain");

    // Response stall: held outputs, no grant while in RESP
    @(posedge clk);
    #1;
    rsp_ready       = 1'b0;
    req_angle[11:6] = 6'd6;
    req_valid       = 4'b0010;
    sb.push_back('{id: 2'd1, cos: 9'h040, sin: 9'h06E, err: 1'b0});
    wait_grant("stall_gnt_timeout", got);
    chk("stall_gnt", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    req_angle[17:12] = 6'd12;
    req_valid        = 4'b0100;
    sb.push_back(model(2, 12));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_id",    32'(rsp_id),    32'd1);
      chk("stall_cos",   32'(rsp_cos),   32'h040);
      chk("stall_sin",   32'(rsp_sin),   32'h06E);
      chk("stall_noreq", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("stall_next_gnt", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("stall_drain");

    // Reset during SIN discards the request and clears the rr pointer
    @(posedge clk);
    #1;
    req_angle[5:0] = 6'd3;
    req_valid      = 4'b0001;
    wait_grant("rstmid_gnt_timeout", got);
    chk("rstmid_gnt", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_cos",   32'(rsp_cos),   32'd0);
    chk("rstmid_sin",   32'(rsp_sin),   32'd0);
    chk("rstmid_id",    32'(rsp_id),    32'd0);
    chk("rstmid_err",   32'(rsp_err),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    req_angle = {6'd1, 6'd2, 6'd4, 6'd18};
    req_valid = 4'hF;
    sb.push_back(model(0, 18));
    wait_grant("rstmid_rr_timeout", got);
    chk("rstmid_rr_ptr", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("rstmid_drain");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
